// File: rtl/pkt_tx.sv
// pkt_tx: transmit-side framer for the vehicle packet link.
//
// Buffers 16-bit payload requests (with destination ID) in a DEPTH-entry FIFO
// and serializes each as a 4-byte frame {dest, src, payload[15:8], payload[7:0]}
// over a byte-wide valid/ready link. A kill request queues one broadcast kill
// frame {KILL_ID, src, KILL_PAYLOAD} that takes priority at the next frame
// boundary; it never preempts a frame in flight and never flushes the FIFO.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   src_id         own vehicle ID, captured when a frame is loaded
//   req_dest       request destination ID
//   req_data       request payload
//   req_valid      request offered
//   req_ready      FIFO has room (registered occupancy only)
//   kill_req       pulse: queue a broadcast kill frame
//   tx_frame       outgoing byte (0 when idle)
//   tx_valid       tx_frame valid
//   tx_ready       downstream accepts byte
//   busy           frame in progress, kill pending, or FIFO non-empty
//   fifo_count     FIFO occupancy
module pkt_tx #(
    parameter int unsigned DEPTH        = 4,
    parameter logic [7:0]  KILL_ID      = 8'hFF,
    parameter logic [15:0] KILL_PAYLOAD = 16'hFFFF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               src_id,
    input  logic [7:0]               req_dest,
    input  logic [15:0]              req_data,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     kill_req,
    output logic [7:0]               tx_frame,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic {
        S_IDLE,
        S_SEND
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [31:0]     frame_q, frame_d;
    logic            kill_q, kill_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [23:0]     mem_q [DEPTH];

    logic            push;
    logic            pop;
    logic            fifo_empty;
    logic            byte_done;
    logic            frame_end;
    logic            boundary;
    logic            load_kill;
    logic            load_fifo;
    logic [23:0]     head;
    logic [7:0]      cur_byte;

    assign req_ready  = (count_q != CW'(DEPTH));
    assign fifo_empty = (count_q == '0);
    assign push       = req_valid && req_ready;
    assign head       = mem_q[rd_ptr_q];

    assign byte_done  = (state_q == S_SEND) && tx_ready;
    assign frame_end  = byte_done && (idx_q == 2'd3);
    // Next frame may be loaded from IDLE or on the cycle byte3 is accepted,
    // which gives back-to-back frames with no bubble.
    assign boundary   = (state_q == S_IDLE) || frame_end;
    assign load_kill  = boundary && kill_q;
    assign load_fifo  = boundary && !kill_q && !fifo_empty;
    assign pop        = load_fifo;

    // FIFO bookkeeping
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Framer FSM next state
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        frame_d = frame_q;
        kill_d  = kill_q;

        if (load_kill) kill_d = 1'b0;
        // A new pulse wins over the clear so a kill arriving as the kill frame
        // is loaded still yields one further kill frame.
        if (kill_req)  kill_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (load_kill) begin
                    frame_d = {KILL_ID, src_id, KILL_PAYLOAD};
                    idx_d   = 2'd0;
                    state_d = S_SEND;
                end else if (load_fifo) begin
                    frame_d = {head[23:16], src_id, head[15:0]};
                    idx_d   = 2'd0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (byte_done) begin
                    if (idx_q != 2'd3) begin
                        idx_d = idx_q + 2'd1;
                    end else if (load_kill) begin
                        frame_d = {KILL_ID, src_id, KILL_PAYLOAD};
                        idx_d   = 2'd0;
                    end else if (load_fifo) begin
                        frame_d = {head[23:16], src_id, head[15:0]};
                        idx_d   = 2'd0;
                    end else begin
                        idx_d   = 2'd0;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= 2'd0;
            frame_q  <= '0;
            kill_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            frame_q  <= frame_d;
            kill_q   <= kill_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy tracks validity.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {req_dest, req_data};
    end

    always_comb begin
        case (idx_q)
            2'd0:    cur_byte = frame_q[31:24];
            2'd1:    cur_byte = frame_q[23:16];
            2'd2:    cur_byte = frame_q[15:8];
            default: cur_byte = frame_q[7:0];
        endcase
    end

    assign tx_valid   = (state_q == S_SEND);
    assign tx_frame   = tx_valid ? cur_byte : 8'h00;
    assign busy       = (state_q != S_IDLE) || kill_q || !fifo_empty;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_pkt_tx.sv
// Testbench for pkt_tx: cycle-by-cycle vector table plus a reset-mid-frame
// sequence.
module tb_pkt_tx;

    logic        clk;
    logic        rst_n;
    logic [7:0]  src_id;
    logic [7:0]  req_dest;
    logic [15:0] req_data;
    logic        req_valid;
    logic        req_ready;
    logic        kill_req;
    logic [7:0]  tx_frame;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic [2:0]  fifo_count;

    int unsigned n_chk;
    int unsigned n_pass;

    pkt_tx #(
        .DEPTH        (4),
        .KILL_ID      (8'hFF),
        .KILL_PAYLOAD (16'hFFFF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .src_id     (src_id),
        .req_dest   (req_dest),
        .req_data   (req_data),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .kill_req   (kill_req),
        .tx_frame   (tx_frame),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One row per cycle: expected outputs seen during the cycle, then the
    // inputs applied for the following rising edge.
    typedef struct {
        logic [7:0]  src;
        logic        rv;
        logic [7:0]  dest;
        logic [15:0] data;
        logic        kill;
        logic        tr;
        logic        ev;
        logic [7:0]  ef;
        logic        rr;
        logic [2:0]  cnt;
        logic        bsy;
    } vec_t;

    vec_t tbl[$];

    task automatic v(input logic [7:0] src, input logic rv, input logic [7:0] dest,
                     input logic [15:0] data, input logic kill, input logic tr,
                     input logic ev, input logic [7:0] ef, input logic rr,
                     input logic [2:0] cnt, input logic bsy);
        vec_t e;
        e.src = src; e.rv = rv; e.dest = dest; e.data = data; e.kill = kill; e.tr = tr;
        e.ev = ev; e.ef = ef; e.rr = rr; e.cnt = cnt; e.bsy = bsy;
        tbl.push_back(e);
    endtask

    // Idle expectation, no stimulus.
    task automatic idle_row();
        v(8'h05, 0, 8'h00, 16'h0000, 0, 1, 0, 8'h00, 1, 3'd0, 0);
    endtask

    // Four frame bytes with tx_ready high, FIFO occupancy constant.
    task automatic fr(input logic [7:0] dest, input logic [15:0] data, input logic [2:0] cnt);
        logic rr;
        rr = (cnt != 3'd4);
        v(8'h05, 0, 8'h00, 16'h0000, 0, 1, 1, dest,        rr, cnt, 1);
        v(8'h05, 0, 8'h00, 16'h0000, 0, 1, 1, 8'h05,       rr, cnt, 1);
        v(8'h05, 0, 8'h00, 16'h0000, 0, 1, 1, data[15:8],  rr, cnt, 1);
        v(8'h05, 0, 8'h00, 16'h0000, 0, 1, 1, data[7:0],   rr, cnt, 1);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic chk_out(input string tag, input logic ev, input logic [7:0] ef,
                           input logic rr, input logic [2:0] cnt, input logic bsy);
        chk({tag, " tx_valid"},   32'(tx_valid),   32'(ev));
        chk({tag, " tx_frame"},   32'(tx_frame),   32'(ef));
        chk({tag, " req_ready"},  32'(req_ready),  32'(rr));
        chk({tag, " fifo_count"}, 32'(fifo_count), 32'(cnt));
        chk({tag, " busy"},       32'(busy),       32'(bsy));
    endtask

    task automatic drive(input logic rv, input logic [7:0] dest, input logic [15:0] data,
                         input logic kill, input logic tr);
        req_valid = rv; req_dest = dest; req_data = data; kill_req = kill; tx_ready = tr;
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        rst_n = 1'b0;
        src_id = 8'h05;
        drive(0, 8'h00, 16'h0000, 0, 1);

        // Single frame
        v(8'h05, 1, 8'h12, 16'hABCD, 0, 1, 0, 8'h00, 1, 3'd0, 0);
        v(8'h05, 0, 8'h00, 16'h0000, 0, 1, 0, 8'h00, 1, 3'd1, 1);
        fr(8'h12, 16'hABCD, 3'd0);
        idle_row();

        // Backpressure
        v(8'h05, 1, 8'h12, 16'hABCD, 0, 1, 0, 8'h00, 1, 3'd0, 0);
        v(8'h05, 0, 8'h00, 16'h0000, 0, 1, 0, 8'h00, 1, 3'd1, 1);
        v(8'h05, 0, 8'h00, 16'h0000, 0, 1, 1, 8'h12, 1, 3'd0, 1);
        v(8'h05, 0, 8'h00, 16'h0000, 0, 0, 1, 8'h05, 1, 3'd0, 1);
        v(8'h05, 0, 8'h00, 16'h0000, 0, 0, 1, 8'h05, 1, 3'd0, 1);
        v(8'h05, 0, 8'h00, 16'h0000, 0, 1, 1, 8'h05, 1, 3'd0, 1);
        v(8'h05, 0, 8'h00, 16'h0000, 0, 0, 1, 8'hAB, 1, 3'd0, 1);
        v(8'h05, 0, 8'h00, 16'h0000, 0, 1, 1, 8'hAB, 1, 3'd0, 1);
        v(8'h05, 0, 8'h00, 16'h0000, 0, 0, 1, 8'hCD, 1, 3'd0, 1);
        v(8'h05, 0, 8'h00, 16'h0000, 0, 1, 1, 8'hCD, 1, 3'd0, 1);
        idle_row();

        // Full FIFO: A loaded, B..E fill the FIFO, F is refused
        v(8'h05, 1, 8'h21, 16'hA1A2, 0, 0, 0, 8'h00, 1, 3'd0, 0);
        v(8'h05, 1, 8'h22, 16'hB1B2, 0, 0, 0, 8'h00, 1, 3'd1, 1);
        v(8'h05, 1, 8'h23, 16'hC1C2, 0, 0, 1, 8'h21, 1, 3'd1, 1);
        v(8'h05, 1, 8'h24, 16'hD1D2, 0, 0, 1, 8'h21, 1, 3'd2, 1);
        v(8'h05, 1, 8'h25, 16'hE1E2, 0, 0, 1, 8'h21, 1, 3'd3, 1);
        v(8'h05, 1, 8'h26, 16'hF1F2, 0, 0, 1, 8'h21, 0, 3'd4, 1);
        v(8'h05, 0, 8'h00, 16'h0000, 0, 1, 1, 8'h21, 0, 3'd4, 1);
        v(8'h05, 0, 8'h00, 16'h0000, 0, 1, 1, 8'h05, 0, 3'd4, 1);
        v(8'h05, 0, 8'h00, 16'h0000, 0, 1, 1, 8'hA1, 0, 3'd4, 1);
        v(8'h05, 0, 8'h00, 16'h0000, 0, 1, 1, 8'hA2, 0, 3'd4, 1);
        fr(8'h22, 16'hB1B2, 3'd3);
        fr(8'h23, 16'hC1C2, 3'd2);
        fr(8'h24, 16'hD1D2, 3'd1);
        fr(8'h25, 16'hE1E2, 3'd0);
        idle_row();

        // Kill priority: two pulses during A, B queued
        v(8'h05, 1, 8'h41, 16'hA5A6, 0, 1, 0, 8'h00, 1, 3'd0, 0);
        v(8'h05, 1, 8'h42, 16'hB5B6, 0, 1, 0, 8'h00, 1, 3'd1, 1);
        v(8'h05, 0, 8'h00, 16'h0000, 1, 1, 1, 8'h41, 1, 3'd1, 1);
        v(8'h05, 0, 8'h00, 16'h0000, 0, 1, 1, 8'h05, 1, 3'd1, 1);
        v(8'h05, 0, 8'h00, 16'h0000, 1, 1, 1, 8'hA5, 1, 3'd1, 1);
        v(8'h05, 0, 8'h00, 16'h0000, 0, 1, 1, 8'hA6, 1, 3'd1, 1);
        fr(8'hFF, 16'hFFFF, 3'd1);
        fr(8'h42, 16'hB5B6, 3'd0);
        idle_row();

        // Kill during a kill frame in flight re-arms exactly one more
        v(8'h05, 0, 8'h00, 16'h0000, 1, 1, 0, 8'h00, 1, 3'd0, 0);
        v(8'h05, 0, 8'h00, 16'h0000, 0, 1, 0, 8'h00, 1, 3'd0, 1);
        v(8'h05, 0, 8'h00, 16'h0000, 1, 1, 1, 8'hFF, 1, 3'd0, 1);
        v(8'h05, 0, 8'h00, 16'h0000, 0, 1, 1, 8'h05, 1, 3'd0, 1);
        v(8'h05, 0, 8'h00, 16'h0000, 0, 1, 1, 8'hFF, 1, 3'd0, 1);
        v(8'h05, 0, 8'h00, 16'h0000, 0, 1, 1, 8'hFF, 1, 3'd0, 1);
        fr(8'hFF, 16'hFFFF, 3'd0);
        idle_row();

        // Normal request to KILL_ID; src_id changes after load
        v(8'h05, 1, 8'hFF, 16'h1234, 0, 1, 0, 8'h00, 1, 3'd0, 0);
        v(8'h05, 0, 8'h00, 16'h0000, 0, 1, 0, 8'h00, 1, 3'd1, 1);
        v(8'h77, 0, 8'h00, 16'h0000, 0, 1, 1, 8'hFF, 1, 3'd0, 1);
        v(8'h77, 0, 8'h00, 16'h0000, 0, 1, 1, 8'h05, 1, 3'd0, 1);
        v(8'h77, 0, 8'h00, 16'h0000, 0, 1, 1, 8'h12, 1, 3'd0, 1);
        v(8'h77, 0, 8'h00, 16'h0000, 0, 1, 1, 8'h34, 1, 3'd0, 1);
        idle_row();

        // Reset phase
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            @(negedge clk);
            chk_out($sformatf("v%0d", i), tbl[i].ev, tbl[i].ef, tbl[i].rr, tbl[i].cnt, tbl[i].bsy);
            src_id = tbl[i].src;
            drive(tbl[i].rv, tbl[i].dest, tbl[i].data, tbl[i].kill, tbl[i].tr);
        end

        // Reset mid-frame: abort after byte1 accepted with one request queued
        @(negedge clk);
        src_id = 8'h05;
        drive(1, 8'h51, 16'h5152, 0, 1);
        @(negedge clk);
        drive(1, 8'h52, 16'h5354, 0, 1);
        @(negedge clk);
        drive(0, 8'h00, 16'h0000, 0, 1);
        chk_out("rst c2", 1, 8'h51, 1, 3'd1, 1);
        @(negedge clk);
        chk_out("rst c3", 1, 8'h05, 1, 3'd1, 1);
        @(negedge clk);
        chk_out("rst c4", 1, 8'h51, 1, 3'd1, 1);
        #2 rst_n = 1'b0;
        #1 chk_out("rst async", 0, 8'h00, 1, 3'd0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_out("post idle", 0, 8'h00, 1, 3'd0, 0);
        drive(1, 8'h61, 16'h6162, 0, 1);
        @(negedge clk);
        drive(0, 8'h00, 16'h0000, 0, 1);
        chk_out("post c1", 0, 8'h00, 1, 3'd1, 1);
        @(negedge clk);
        chk_out("post b0", 1, 8'h61, 1, 3'd0, 1);
        @(negedge clk);
        chk_out("post b1", 1, 8'h05, 1, 3'd0, 1);
        @(negedge clk);
        chk_out("post b2", 1, 8'h61, 1, 3'd0, 1);
        @(negedge clk);
        chk_out("post b3", 1, 8'h62, 1, 3'd0, 1);
        @(negedge clk);
        chk_out("post end", 0, 8'h00, 1, 3'd0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
